// File: rtl/hilo_mul_seq.sv
// Sequential shift-add multiply / multiply-accumulate unit owning the HI/LO pair.
// One iteration per clock; HI/LO update on the ACC edge or on MTHI/MTLO writes in IDLE.
module hilo_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [1:0]       op_q;
    logic             neg_q;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    product;
    logic [CNT_W-1:0] cnt;

    logic             signed_op;
    logic             start_go;
    logic             acc_op;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    prod_s;
    logic [PW-1:0]    hilo_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && !flush) state_nxt = S_MULT;
            S_MULT: begin
                if (flush)                          state_nxt = S_IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))  state_nxt = S_ACC;
            end
            S_ACC:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Magnitudes: negating 0x8000_0000 yields 2^(WIDTH-1), still correct as unsigned.
    always_comb begin
        signed_op = op[0];
        start_go  = (state == S_IDLE) && start && !flush;
        mag_a     = (signed_op && operand_a[WIDTH-1]) ? (-operand_a) : operand_a;
        mag_b     = (signed_op && operand_b[WIDTH-1]) ? (-operand_b) : operand_b;
        acc_op    = op_q[0] ^ op_q[1];
        prod_s    = neg_q ? (-product) : product;
        hilo_sum  = {hi_out, lo_out} + prod_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            neg_q   <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            cnt     <= '0;
            hi_out  <= '0;
            lo_out  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state == S_ACC) && !flush;

            if (start_go) begin
                op_q    <= op;
                mcand   <= PW'(mag_a);
                mplier  <= mag_b;
                neg_q   <= signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                product <= '0;
                cnt     <= '0;
            end

            if ((state == S_MULT) && !flush) begin
                if (mplier[0]) product <= product + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end

            // Architectural writes are only honoured while idle.
            if (state == S_IDLE) begin
                if (hi_wr) hi_out <= wr_data;
                if (lo_wr) lo_out <= wr_data;
            end

            if ((state == S_ACC) && !flush) begin
                {hi_out, lo_out} <= acc_op ? hilo_sum : prod_s;
            end
        end
    end

endmodule

// File: tb/tb_hilo_mul_seq.sv
// Directed self-checking bench for hilo_mul_seq with hand-computed HI/LO results.
module tb_hilo_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] OP_MUL = 2'b00, OP_MADD = 2'b01, OP_MADDU = 2'b10, OP_MULT = 2'b11;

    hilo_mul_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        step();
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        op = 2'bxx; operand_a = 'x; operand_b = 'x;
    endtask

    // Waits (bounded) for done; reports edges after the start edge and busy cycles seen.
    task automatic wait_done(output int done_at, output int busy_n, output bit got);
        got = 1'b0; busy_n = 0; done_at = -1;
        for (int i = 0; i < 45; i++) begin
            if (done) begin
                got = 1'b1; done_at = i;
                break;
            end
            if (busy) busy_n++;
            step();
        end
    endtask

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (done) pulses++;
            step();
        end
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        wr_data = h; hi_wr = 1'b1; step(); hi_wr = 1'b0;
        wr_data = l; lo_wr = 1'b1; step(); lo_wr = 1'b0;
    endtask

    int  done_at, busy_n, pulses;
    bit  got;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = OP_MUL; operand_a = '0; operand_b = '0;
        flush = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
        #12;
        chk("reset_state", {30'd0, busy, done, hi_out}, 64'd0);
        chk("reset_lo", {32'd0, lo_out}, 64'd0);
        #4 rst_n = 1'b1;
        step();

        // Async reset mid-cycle clears HI/LO immediately
        write_hilo(32'h0000_1234, 32'h0000_5678);
        chk("mthi_mtlo", {hi_out, lo_out}, 64'h0000_1234_0000_5678);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_idle", {30'd0, busy, done, hi_out, lo_out[31:30]}, 64'd0);
        chk("async_rst_idle_lo", {32'd0, lo_out}, 64'd0);
        #3 rst_n = 1'b1;
        step();

        // Reset at iteration 10 of a MUL
        write_hilo(32'h55, 32'h66);
        launch(OP_MUL, 32'd5, 32'd7);
        repeat (10) step();
        chk("busy_before_rst", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_op_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_mid_op_hilo", {hi_out, lo_out}, 64'd0);
        #3 rst_n = 1'b1;
        count_done(40, pulses);
        chk("rst_mid_op_no_done", 64'(pulses), 64'd0);

        // MUL 0xFFFFFFFF^2 with exact latency
        launch(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(done_at, busy_n, got);
        chk("mul_max_got_done", {63'd0, got}, 64'd1);
        chk("mul_max_done_edge", 64'(done_at), 64'd33);
        chk("mul_max_busy_cycles", 64'(busy_n), 64'd33);
        chk("mul_max_busy_at_done", {63'd0, busy}, 64'd0);
        chk("mul_max_result", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
        step();
        chk("done_single_pulse", {63'd0, done}, 64'd0);

        // MULT signed
        launch(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(done_at, busy_n, got);
        chk("mult_minint_sq", {hi_out, lo_out}, 64'h4000_0000_0000_0000);
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(done_at, busy_n, got);
        chk("mult_neg3x5", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);

        // MADD onto written HI=0, LO=10
        write_hilo(32'd0, 32'd10);
        chk("mtlo_visible", {hi_out, lo_out}, 64'h0000_0000_0000_000A);
        launch(OP_MADD, 32'hFFFF_FFFD, 32'd5);
        wait_done(done_at, busy_n, got);
        chk("madd_neg3x5", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFB);

        // MADDU wraps
        write_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        launch(OP_MADDU, 32'd1, 32'd1);
        wait_done(done_at, busy_n, got);
        chk("maddu_wrap", {hi_out, lo_out}, 64'd0);

        // Same-cycle start + lo_wr
        wr_data = 32'd7; lo_wr = 1'b1;
        launch(OP_MADDU, 32'd2, 32'd3);
        chk("same_cycle_lo_wr", {hi_out, lo_out}, 64'd7);
        wait_done(done_at, busy_n, got);
        chk("maddu_after_lo_wr", {hi_out, lo_out}, 64'd13);

        // start and hi_wr while busy are ignored
        launch(OP_MUL, 32'd3, 32'd4);
        repeat (5) step();
        op = OP_MUL; operand_a = 32'd100; operand_b = 32'd100; start = 1'b1;
        wr_data = 32'hDEAD_BEEF; hi_wr = 1'b1;
        step();
        start = 1'b0; hi_wr = 1'b0;
        chk("hi_wr_busy_ignored", {32'd0, hi_out}, 64'd0);
        wait_done(done_at, busy_n, got);
        chk("busy_start_ignored", {hi_out, lo_out}, 64'd12);
        step();
        count_done(40, pulses);
        chk("no_queued_op", 64'(pulses), 64'd0);

        // flush at iteration 10
        launch(OP_MUL, 32'd9, 32'd9);
        repeat (10) step();
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_busy_drop", {62'd0, busy, done}, 64'd0);
        chk("flush_hilo_kept", {hi_out, lo_out}, 64'd12);
        count_done(40, pulses);
        chk("flush_no_done", 64'(pulses), 64'd0);

        // flush beats start in IDLE
        op = OP_MUL; operand_a = 32'd2; operand_b = 32'd2; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush_over_start", {63'd0, busy}, 64'd0);

        launch(OP_MULT, 32'd6, 32'hFFFF_FFF9);
        wait_done(done_at, busy_n, got);
        chk("post_flush_mult", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFD6);
        chk("post_flush_latency", 64'(done_at), 64'd33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
